// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: serializer FSM states and a width-generic ReLU.
// The function works on a wide signed wrapper type; callers sign-extend into it and truncate back.
package cnn_pkg;

    typedef enum logic [0:0] {
        eIDLE = 1'b0,
        eSEND = 1'b1
    } serializer_state_e;

    localparam int RELU_MAX_W = 64;

    typedef logic signed [RELU_MAX_W-1:0] relu_word_t;

    // Sign extension into the wrapper puts the word's sign bit in the wrapper MSB.
    function automatic relu_word_t relu(input relu_word_t w);
        return w[RELU_MAX_W-1] ? '0 : w;
    endfunction

endpackage

// File: rtl/relu_word.sv
// Combinational clamp of one signed fixed-point word to zero when negative.
module relu_word
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic signed [WORD_SIZE-1:0] word_i,
    output logic signed [WORD_SIZE-1:0] word_o
);

    relu_word_t ext;

    assign ext    = RELU_MAX_W'(word_i);
    assign word_o = WORD_SIZE'(relu(ext));

endmodule

// File: rtl/layer_serializer.sv
// Captures a full multi-channel layer output and streams it word by word,
// row-major with channels interleaved, over a valid/ready handshake.
module layer_serializer
    import cnn_pkg::*;
#(
    parameter int LAYER_HEIGHT = 60,
    parameter int NUM_CHANNELS = 2,
    parameter int WORD_SIZE    = 16,
    parameter int APPLY_RELU   = 1
) (
    input  logic                                                    clk_i,
    input  logic                                                    reset_i,
    input  logic                                                    valid_i,
    output logic                                                    yumi_o,
    input  logic [NUM_CHANNELS-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    output logic                                                    start_o,
    output logic                                                    valid_o,
    input  logic                                                    ready_i,
    output logic [WORD_SIZE-1:0]                                    data_o
);

    localparam int R_W = $clog2(LAYER_HEIGHT + 1);
    localparam int C_W = $clog2(NUM_CHANNELS + 1);

    typedef logic [NUM_CHANNELS-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] layer_t;

    serializer_state_e state_q, state_d;
    logic [R_W-1:0]    r_q, r_d;
    logic [C_W-1:0]    c_q, c_d;
    layer_t            buffer_q, buffer_d;
    layer_t            relu_data;
    logic              start_q, start_d;

    logic capture;
    logic handshake;
    logic last_word;

    for (genvar gc = 0; gc < NUM_CHANNELS; gc++) begin : g_chan
        for (genvar gr = 0; gr < LAYER_HEIGHT; gr++) begin : g_row
            if (APPLY_RELU != 0) begin : g_relu
                relu_word #(
                    .WORD_SIZE(WORD_SIZE)
                ) u_relu (
                    .word_i(data_i[gc][gr]),
                    .word_o(relu_data[gc][gr])
                );
            end else begin : g_pass
                assign relu_data[gc][gr] = data_i[gc][gr];
            end
        end
    end

    assign capture   = (state_q == eIDLE) && valid_i;
    assign handshake = (state_q == eSEND) && ready_i;
    assign last_word = (r_q == R_W'(LAYER_HEIGHT - 1)) && (c_q == C_W'(NUM_CHANNELS - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eIDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            eIDLE:   if (valid_i) state_d = eSEND;
            eSEND:   if (handshake && last_word) state_d = eIDLE;
            default: state_d = eIDLE;
        endcase
    end

    always_comb begin
        yumi_o  = capture && !reset_i;
        valid_o = (state_q == eSEND);
        start_o = start_q;
        data_o  = '0;
        if (state_q == eSEND) begin
            for (int ci = 0; ci < NUM_CHANNELS; ci++) begin
                for (int ri = 0; ri < LAYER_HEIGHT; ri++) begin
                    if ((c_q == C_W'(ci)) && (r_q == R_W'(ri))) begin
                        data_o = buffer_q[ci][ri];
                    end
                end
            end
        end
    end

    // Channel index is the fast-moving one; the row advances when it wraps.
    always_comb begin
        r_d      = r_q;
        c_d      = c_q;
        buffer_d = buffer_q;
        start_d  = capture;
        if (capture) begin
            buffer_d = relu_data;
            r_d      = '0;
            c_d      = '0;
        end else if (handshake) begin
            if (last_word) begin
                r_d = '0;
                c_d = '0;
            end else if (c_q == C_W'(NUM_CHANNELS - 1)) begin
                c_d = '0;
                r_d = r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_q      <= '0;
            c_q      <= '0;
            buffer_q <= '0;
            start_q  <= 1'b0;
        end else begin
            r_q      <= r_d;
            c_q      <= c_d;
            buffer_q <= buffer_d;
            start_q  <= start_d;
        end
    end

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer: 4 rows x 2 channels, ReLU on (dut_a) and off (dut_b).
module tb_layer_serializer;

    localparam int LH = 4;
    localparam int NC = 2;
    localparam int WS = 16;
    localparam int NW = LH * NC;

    logic                         clk     = 1'b0;
    logic                         reset_i = 1'b1;
    logic                         valid_i = 1'b0;
    logic                         ready_i = 1'b0;
    logic [NC-1:0][LH-1:0][WS-1:0] data_i = '0;

    logic          yumi_a, start_a, valid_a;
    logic [WS-1:0] data_a;
    logic          yumi_b, start_b, valid_b;
    logic [WS-1:0] data_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [WS-1:0] exp_a [NW];
    logic [WS-1:0] exp_b [NW];
    bit            rdy_pat [16];
    int            rdy_len = 0;

    layer_serializer #(
        .LAYER_HEIGHT(LH), .NUM_CHANNELS(NC), .WORD_SIZE(WS), .APPLY_RELU(1)
    ) dut_a (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .yumi_o(yumi_a),
        .data_i(data_i), .start_o(start_a), .valid_o(valid_a), .ready_i(ready_i),
        .data_o(data_a)
    );

    layer_serializer #(
        .LAYER_HEIGHT(LH), .NUM_CHANNELS(NC), .WORD_SIZE(WS), .APPLY_RELU(0)
    ) dut_b (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .yumi_o(yumi_b),
        .data_i(data_i), .start_o(start_b), .valid_o(valid_b), .ready_i(ready_i),
        .data_o(data_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input logic [WS-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
        data_i[0][0] = a0; data_i[0][1] = a1; data_i[0][2] = a2; data_i[0][3] = a3;
        data_i[1][0] = b0; data_i[1][1] = b1; data_i[1][2] = b2; data_i[1][3] = b3;
    endtask

    task automatic set_exp(input logic [WS-1:0] w0, w1, w2, w3, w4, w5, w6, w7, input logic [WS-1:0] relu_off_w2);
        exp_a[0] = w0; exp_a[1] = w1; exp_a[2] = w2; exp_a[3] = w3;
        exp_a[4] = w4; exp_a[5] = w5; exp_a[6] = w6; exp_a[7] = w7;
        exp_b    = exp_a;
        exp_b[2] = relu_off_w2;
    endtask

    // Leaves the bench at posedge+1 of the first send cycle.
    task automatic capture(input string tag, input bit hold);
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        @(negedge clk);
        check({tag, "_yumi"}, {31'd0, yumi_a}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) valid_i = 1'b0;
    endtask

    task automatic stream(input string tag, input bit busy);
        int            got = 0;
        int            cyc = 0;
        bit            stalled = 1'b0;
        logic [WS-1:0] held = '0;
        while (got < NW && cyc < 40) begin
            ready_i = (cyc < rdy_len) ? rdy_pat[cyc] : 1'b1;
            @(negedge clk);
            check({tag, "_valid"}, {31'd0, valid_a}, 32'd1);
            check({tag, "_start"}, {31'd0, start_a}, {31'd0, (cyc == 0)});
            if (stalled) check({tag, "_hold"}, {16'd0, data_a}, {16'd0, held});
            if (busy) check({tag, "_yumi_busy"}, {31'd0, yumi_a}, 32'd0);
            if (ready_i) begin
                check($sformatf("%s_word%0d", tag, got), {16'd0, data_a}, {16'd0, exp_a[got]});
                check($sformatf("%s_word%0d_norelu", tag, got), {16'd0, data_b}, {16'd0, exp_b[got]});
                got++;
                stalled = 1'b0;
            end else begin
                held    = data_a;
                stalled = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (got < NW) check({tag, "_timeout"}, got, NW);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, including valid_i high while reset is asserted
        reset_i = 1'b1;
        valid_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_yumi_in_reset", {31'd0, yumi_a}, 32'd0);
        check("rst_valid_in_reset", {31'd0, valid_a}, 32'd0);
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_yumi", {31'd0, yumi_a}, 32'd0);
        check("rst_start", {31'd0, start_a}, 32'd0);
        check("rst_data", {16'd0, data_a}, 32'd0);

        // Basic frame
        set_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30, 16'd40);
        set_exp(16'd1, 16'd10, 16'd2, 16'd20, 16'd3, 16'd30, 16'd4, 16'd40, 16'd2);
        capture("basic", 1'b0);
        stream("basic", 1'b0);
        @(negedge clk);
        check("basic_idle_after", {31'd0, valid_a}, 32'd0);

        // ReLU on dut_a vs bypass on dut_b
        set_frame(16'd1, 16'hFFF0, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30, 16'd40);
        set_exp(16'd1, 16'd10, 16'd0, 16'd20, 16'd3, 16'd30, 16'd4, 16'd40, 16'hFFF0);
        capture("relu", 1'b0);
        stream("relu", 1'b0);

        // Backpressure
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        rdy_len = 10;
        set_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30, 16'd40);
        set_exp(16'd1, 16'd10, 16'd2, 16'd20, 16'd3, 16'd30, 16'd4, 16'd40, 16'd2);
        capture("bp", 1'b0);
        stream("bp", 1'b0);
        rdy_len = 0;
        @(negedge clk);
        check("bp_idle_after", {31'd0, valid_a}, 32'd0);

        // Busy input: valid_i held high with the next frame waiting
        capture("busy1", 1'b1);
        set_frame(16'd5, 16'd6, 16'd7, 16'd8, 16'd50, 16'd60, 16'd70, 16'd80);
        stream("busy1", 1'b1);
        @(negedge clk);
        check("busy_yumi_pulse", {31'd0, yumi_a}, 32'd1);
        check("busy_bubble_valid", {31'd0, valid_a}, 32'd0);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        set_exp(16'd5, 16'd50, 16'd6, 16'd60, 16'd7, 16'd70, 16'd8, 16'd80, 16'd6);
        stream("busy2", 1'b0);
        @(negedge clk);
        check("busy_yumi_after", {31'd0, yumi_a}, 32'd0);

        // Reset mid-frame after 3 words
        set_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30, 16'd40);
        capture("midrst", 1'b0);
        ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_word3", {16'd0, data_a}, 32'd20);
        #1;
        reset_i = 1'b1;
        #1;
        check("midrst_valid_drop", {31'd0, valid_a}, 32'd0);
        check("midrst_data_clear", {16'd0, data_a}, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        ready_i = 1'b0;
        set_frame(16'd5, 16'd6, 16'd7, 16'd8, 16'd50, 16'd60, 16'd70, 16'd80);
        set_exp(16'd5, 16'd50, 16'd6, 16'd60, 16'd7, 16'd70, 16'd8, 16'd80, 16'd6);
        capture("after_rst", 1'b0);
        stream("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
